// File: rtl/sram_rd_scheduler_pkg.sv
// Shared constants and types for the SRAM read-port scheduler.
//   DEF_*       : default parameter values for the scheduler top
//   PORT_IDX_W  : port index width for the default port count
//   state_e     : issue FSM encoding
package sram_rd_scheduler_pkg;

    localparam int unsigned DEF_NUM_PORTS = 16;
    localparam int unsigned DEF_ADDR_W    = 17;
    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_LEN_W     = 7;
    localparam int unsigned DEF_RD_LAT    = 1;
    localparam int unsigned PORT_IDX_W    = $clog2(DEF_NUM_PORTS);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/sram_rd_scheduler_rr_pick.sv
// Combinational masked round-robin picker.
//   elig      : eligible requesters
//   mask      : requesters excluded from this pick
//   ptr       : search starts at this index and wraps modulo N
//   found_c   : some unmasked requester is eligible
//   gnt_oh_c  : one-hot winner
//   gnt_idx_c : winner index
module rr_pick #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     elig,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             found_c,
    output logic [N-1:0]     gnt_oh_c,
    output logic [IDX_W-1:0] gnt_idx_c
);

    logic [N-1:0] cand_c;
    int unsigned  pos;

    // Scan N positions starting at ptr; first unmasked eligible wins.
    always_comb begin
        cand_c    = elig & ~mask;
        found_c   = 1'b0;
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        pos       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found_c && cand_c[IDX_W'(pos)]) begin
                found_c                = 1'b1;
                gnt_idx_c              = IDX_W'(pos);
                gnt_oh_c[IDX_W'(pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rd_scheduler.sv
// Shares one SRAM read port among NUM_PORTS packet readers. Grants round-robin,
// issues one read per cycle for a whole packet with back-to-back packets, and
// tags returning words with port/sop/eop.
//   clk, rst                 : clock, async active-low reset
//   req/req_addr/req_len     : per-port packet read requests (packed fields)
//   gnt                      : one-cycle one-hot accept pulse
//   enb/addrb/doutb          : SRAM read port
//   rd_data/rd_vld/rd_sop/rd_eop : returned word and framing, one-hot per port
//   busy                     : reads being issued or still in flight
module sram_rd_scheduler
    import sram_rd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic                        enb,
    output logic [ADDR_W-1:0]           addrb,
    input  logic [DATA_W-1:0]           doutb,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]        rd_vld,
    output logic [NUM_PORTS-1:0]        rd_sop,
    output logic [NUM_PORTS-1:0]        rd_eop,
    output logic                        busy
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               cur_port_q, cur_port_d;
    logic                           first_q, first_d;
    logic [NUM_PORTS-1:0]           gnt_q, gnt_d;
    logic                           enb_q, enb_d;
    logic [ADDR_W-1:0]              addrb_q, addrb_d;

    logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0]   pipe_port_q, pipe_port_d;
    logic [RD_LAT-1:0]              pipe_sop_q, pipe_sop_d;
    logic [RD_LAT-1:0]              pipe_eop_q, pipe_eop_d;

    logic [DATA_W-1:0]              rd_data_q, rd_data_d;
    logic [NUM_PORTS-1:0]           rd_vld_q, rd_vld_d;
    logic [NUM_PORTS-1:0]           rd_sop_q, rd_sop_d;
    logic [NUM_PORTS-1:0]           rd_eop_q, rd_eop_d;
    logic                           busy_q, busy_d;

    logic [NUM_PORTS-1:0]           elig_c;
    logic                           pick_found_c;
    logic [NUM_PORTS-1:0]           pick_oh_c;
    logic [IDX_W-1:0]               pick_idx_c;
    logic [ADDR_W-1:0]              sel_addr_c;
    logic [LEN_W-1:0]               sel_len_c;
    logic                           arb_en_c;
    logic                           start_c;

    // Zero-length requests are never eligible.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            elig_c[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
        end
    end

    // The port granted last cycle is masked so a stale len=1 request is not re-granted.
    rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .elig      (elig_c),
        .mask      (gnt_q),
        .ptr       (rr_ptr_q),
        .found_c   (pick_found_c),
        .gnt_oh_c  (pick_oh_c),
        .gnt_idx_c (pick_idx_c)
    );

    assign sel_addr_c = req_addr[pick_idx_c*ADDR_W +: ADDR_W];
    assign sel_len_c  = req_len[pick_idx_c*LEN_W +: LEN_W];

    // Arbitrate when idle or while issuing the last word of a packet.
    assign arb_en_c = (state_q == IDLE) || (cnt_q == '0);
    assign start_c  = arb_en_c && pick_found_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ISSUE;
        end else if (arb_en_c) begin
            state_d = IDLE;
        end
    end

    // Issue-side outputs and packet bookkeeping.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        cur_port_d = cur_port_q;
        first_d    = 1'b0;
        gnt_d      = '0;
        enb_d      = 1'b0;
        addrb_d    = addrb_q;
        if (start_c) begin
            gnt_d      = pick_oh_c;
            enb_d      = 1'b1;
            addrb_d    = sel_addr_c;
            cnt_d      = sel_len_c - LEN_W'(1);
            cur_port_d = pick_idx_c;
            first_d    = 1'b1;
            rr_ptr_d   = (32'(pick_idx_c) == NUM_PORTS - 1) ? '0 : pick_idx_c + IDX_W'(1);
        end else if ((state_q == ISSUE) && (cnt_q != '0)) begin
            enb_d   = 1'b1;
            addrb_d = addrb_q + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
        end
    end

    // Return path: tag follows each issued word for RD_LAT cycles, then meets doutb.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_port_d    = '0;
        pipe_sop_d     = '0;
        pipe_eop_d     = '0;
        pipe_vld_d[0]  = enb_q;
        pipe_port_d[0] = cur_port_q;
        pipe_sop_d[0]  = enb_q && first_q;
        pipe_eop_d[0]  = enb_q && (cnt_q == '0);
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_port_d[k] = pipe_port_q[k-1];
            pipe_sop_d[k]  = pipe_sop_q[k-1];
            pipe_eop_d[k]  = pipe_eop_q[k-1];
        end

        rd_vld_d  = '0;
        rd_sop_d  = '0;
        rd_eop_d  = '0;
        rd_data_d = rd_data_q;
        if (pipe_vld_q[RD_LAT-1]) begin
            rd_vld_d[pipe_port_q[RD_LAT-1]] = 1'b1;
            rd_sop_d[pipe_port_q[RD_LAT-1]] = pipe_sop_q[RD_LAT-1];
            rd_eop_d[pipe_port_q[RD_LAT-1]] = pipe_eop_q[RD_LAT-1];
            rd_data_d                       = doutb;
        end

        busy_d = (state_d == ISSUE) || (|pipe_vld_d) || (|rd_vld_d);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            cur_port_q  <= '0;
            first_q     <= 1'b0;
            gnt_q       <= '0;
            enb_q       <= 1'b0;
            addrb_q     <= '0;
            pipe_vld_q  <= '0;
            pipe_port_q <= '0;
            pipe_sop_q  <= '0;
            pipe_eop_q  <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= '0;
            rd_sop_q    <= '0;
            rd_eop_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            cur_port_q  <= cur_port_d;
            first_q     <= first_d;
            gnt_q       <= gnt_d;
            enb_q       <= enb_d;
            addrb_q     <= addrb_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_port_q <= pipe_port_d;
            pipe_sop_q  <= pipe_sop_d;
            pipe_eop_q  <= pipe_eop_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            rd_sop_q    <= rd_sop_d;
            rd_eop_q    <= rd_eop_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign enb     = enb_q;
    assign addrb   = addrb_q;
    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
    assign rd_sop  = rd_sop_q;
    assign rd_eop  = rd_eop_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Scoreboard bench for sram_rd_scheduler: stimulus pushes expected grants,
// issued addresses and returned words (with cycle stamps); a negedge monitor
// pops and compares whenever the DUT presents gnt, enb or rd_vld.
`timescale 1ns/1ps
module tb_sram_rd_scheduler;
    import sram_rd_scheduler_pkg::*;

    localparam int unsigned NP = DEF_NUM_PORTS;
    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned LW = DEF_LEN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req;
    logic [NP*AW-1:0] req_addr;
    logic [NP*LW-1:0] req_len;
    logic [NP-1:0]    gnt;
    logic             enb;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    doutb = '0;
    logic [DW-1:0]    rd_data;
    logic [NP-1:0]    rd_vld;
    logic [NP-1:0]    rd_sop;
    logic [NP-1:0]    rd_eop;
    logic             busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct { int port; int cyc; } gnt_exp_t;
    typedef struct { logic [AW-1:0] addr; int cyc; } addr_exp_t;
    typedef struct { int port; logic [DW-1:0] data; bit sop; bit eop; int cyc; } rd_exp_t;

    gnt_exp_t  q_gnt[$];
    addr_exp_t q_addr[$];
    rd_exp_t   q_rd[$];

    sram_rd_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .enb      (enb),
        .addrb    (addrb),
        .doutb    (doutb),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .rd_sop   (rd_sop),
        .rd_eop   (rd_eop),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {15'h0, a, 15'h7fff, ~a};
    endfunction

    // SRAM model, one cycle read latency.
    always @(posedge clk) if (enb) doutb <= mdata(addrb);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input int l);
        req = req | (NP'(1) << p);
        req_addr[p*AW +: AW] = a;
        req_len[p*LW +: LW]  = LW'(l);
    endtask

    task automatic drop_req(input int p);
        req = req & ~(NP'(1) << p);
    endtask

    // Expected grant at gc, words issued gc..gc+len-1, returned two cycles later.
    task automatic push_packet(input int port, input logic [AW-1:0] addr, input int len, input int gc);
        logic [AW-1:0] a;
        q_gnt.push_back('{port: port, cyc: gc});
        for (int k = 0; k < len; k++) begin
            a = addr + AW'(k);
            q_addr.push_back('{addr: a, cyc: gc + k});
            q_rd.push_back('{port: port, data: mdata(a), sop: (k == 0), eop: (k == len - 1), cyc: gc + k + 2});
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_gnt.size() + q_addr.size() + q_rd.size() == 0) break;
            tick();
        end
        chk(name, 64'(q_gnt.size() + q_addr.size() + q_rd.size()), 64'd0);
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin : monitor
        gnt_exp_t      ge;
        addr_exp_t     ae;
        rd_exp_t       re;
        logic [NP-1:0] oh;
        if (rst) begin
            if (gnt != '0) begin
                checks++;
                if (q_gnt.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected: got %b at cycle %0d, required no grant", gnt, cyc);
                end else begin
                    ge = q_gnt.pop_front();
                    oh = NP'(1) << ge.port;
                    if (gnt !== oh || cyc != ge.cyc) begin
                        errors++;
                        $display("FAIL gnt: got %b at cycle %0d, required %b at cycle %0d", gnt, cyc, oh, ge.cyc);
                    end
                end
            end
            if (enb) begin
                checks++;
                if (q_addr.size() == 0) begin
                    errors++;
                    $display("FAIL enb_unexpected: got addrb 0x%0h at cycle %0d, required enb=0", addrb, cyc);
                end else begin
                    ae = q_addr.pop_front();
                    if (addrb !== ae.addr || cyc != ae.cyc) begin
                        errors++;
                        $display("FAIL addrb: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", addrb, cyc, ae.addr, ae.cyc);
                    end
                end
            end
            if (rd_vld != '0) begin
                checks++;
                if (q_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got rd_vld %b at cycle %0d, required none", rd_vld, cyc);
                end else begin
                    re = q_rd.pop_front();
                    oh = NP'(1) << re.port;
                    if (rd_vld !== oh || rd_sop !== (re.sop ? oh : '0) || rd_eop !== (re.eop ? oh : '0)
                        || rd_data !== re.data || cyc != re.cyc) begin
                        errors++;
                        $display("FAIL rd: got vld=%b sop=%b eop=%b data=0x%0h cyc=%0d, required vld=%b sop=%0d eop=%0d data=0x%0h cyc=%0d",
                                 rd_vld, rd_sop, rd_eop, rd_data, cyc, oh, re.sop, re.eop, re.data, re.cyc);
                    end
                end
            end else if ((rd_sop | rd_eop) != '0) begin
                checks++;
                errors++;
                $display("FAIL framing_without_vld: got sop=%b eop=%b at cycle %0d, required 0", rd_sop, rd_eop, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("reset_gnt",    64'(gnt), 64'd0);
        chk("reset_enb",    64'(enb), 64'd0);
        chk("reset_addrb",  64'(addrb), 64'd0);
        chk("reset_rd_vld", 64'(rd_vld), 64'd0);
        chk("reset_busy",   64'(busy), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        rst = 1'b1;
        tick();
        tick();

        // Single packet on port 3.
        t = cyc;
        set_req(3, 17'h00100, 4);
        push_packet(3, 17'h00100, 4, t + 1);
        chk("t1_busy_before", 64'(busy), 64'd0);
        tick();
        tick();
        drop_req(3);
        repeat (4) tick();
        chk("t1_busy_last_word", 64'(busy), 64'd1);
        tick();
        chk("t1_busy_fall", 64'(busy), 64'd0);
        tick();
        chk("t1_rd_data_hold", rd_data, mdata(17'h00103));
        drain("t1_drain", 20);

        // Address wrap on port 15 (also moves rr_ptr back to 0).
        t = cyc;
        set_req(15, 17'h1FFFF, 3);
        push_packet(15, 17'h1FFFF, 3, t + 1);
        tick();
        tick();
        drop_req(15);
        drain("t4_drain", 20);

        // Contention: 0, 5, 15 with len 2; port 7 with len 0 never granted.
        t = cyc;
        set_req(0, 17'h00300, 2);
        set_req(5, 17'h00310, 2);
        set_req(15, 17'h00320, 2);
        set_req(7, 17'h00330, 0);
        push_packet(0, 17'h00300, 2, t + 1);
        push_packet(5, 17'h00310, 2, t + 3);
        push_packet(15, 17'h00320, 2, t + 5);
        tick(); tick();
        drop_req(0);
        tick(); tick();
        drop_req(5);
        tick(); tick();
        drop_req(15);
        tick();
        chk("t2_enb_off", 64'(enb), 64'd0);
        repeat (3) tick();
        drop_req(7);
        drain("t2_drain", 20);

        // Fairness: ports 2 and 9 re-request with len 1 right after each grant.
        t = cyc;
        set_req(2, 17'h00500, 1);
        set_req(9, 17'h00501, 1);
        for (int k = 0; k < 6; k++) begin
            set_req((k % 2 == 0) ? 2 : 9, AW'(17'h00500 + k), 1);
            push_packet((k % 2 == 0) ? 2 : 9, AW'(17'h00500 + k), 1, t + k + 1);
            tick();
        end
        drop_req(2);
        drop_req(9);
        drain("t3_drain", 20);

        // Reset during the third issued word of an 8-word packet.
        t = cyc;
        set_req(10, 17'h00200, 8);
        push_packet(10, 17'h00200, 8, t + 1);
        tick();
        tick();
        drop_req(10);
        tick();
        rst = 1'b0;
        #1;
        q_gnt.delete();
        q_addr.delete();
        q_rd.delete();
        chk("t5_rst_gnt",    64'(gnt), 64'd0);
        chk("t5_rst_enb",    64'(enb), 64'd0);
        chk("t5_rst_addrb",  64'(addrb), 64'd0);
        chk("t5_rst_rd_vld", 64'(rd_vld | rd_sop | rd_eop), 64'd0);
        chk("t5_rst_busy",   64'(busy), 64'd0);
        chk("t5_rst_data",   rd_data, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("t5_quiet_busy", 64'(busy), 64'd0);
        t = cyc;
        set_req(1, 17'h00600, 1);
        set_req(12, 17'h00610, 1);
        push_packet(1, 17'h00600, 1, t + 1);
        push_packet(12, 17'h00610, 1, t + 2);
        tick();
        tick();
        drop_req(1);
        tick();
        drop_req(12);
        drain("t5_drain", 20);

        // Stale len-1 request on port 4 held through its grant cycle.
        t = cyc;
        set_req(4, 17'h00700, 1);
        set_req(6, 17'h00710, 1);
        push_packet(4, 17'h00700, 1, t + 1);
        push_packet(6, 17'h00710, 1, t + 2);
        tick();
        tick();
        drop_req(4);
        tick();
        drop_req(6);
        drain("t6_drain", 20);
        repeat (4) tick();
        chk("end_queues", 64'(q_gnt.size() + q_addr.size() + q_rd.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
